// File: rtl/point_serve_ctrl_if.sv
// Judge-to-ball-engine control bundle: judge score/endgame in, ball engine control out.
// master drives the judge side, slave is the serve controller.
interface point_serve_ctrl_if;
   logic [3:0]  score_player1;
   logic [3:0]  score_player2;
   logic        endgame;
   logic        ball_freeze;
   logic        ball_reset;
   logic [11:0] ball_xspawn;
   logic [11:0] ball_yspawn;
   logic        serving_player;
   logic [1:0]  winner;
   logic        point_led;

   modport master (
      output score_player1, score_player2, endgame,
      input  ball_freeze, ball_reset, ball_xspawn, ball_yspawn,
             serving_player, winner, point_led
   );

   modport slave (
      input  score_player1, score_player2, endgame,
      output ball_freeze, ball_reset, ball_xspawn, ball_yspawn,
             serving_player, winner, point_led
   );
endinterface

// File: rtl/point_serve_ctrl.sv
// Point/serve sequencer: freezes the ball after each point, respawns it on the winner's side,
// and locks it on endgame. Optional feature macro SERVE_BLINK_EN blinks point_led during freeze.
module point_serve_ctrl #(
   parameter int          FREEZE_CYCLES = 195_000_000,
   parameter logic [11:0] SERVE_X1      = 12'd250,
   parameter logic [11:0] SERVE_X2      = 12'd773,
   parameter logic [11:0] SERVE_Y       = 12'd300,
   parameter int          BLINK_CYCLES  = 16_250_000
) (
   input logic               clk,
   input logic               rst_n,
   point_serve_ctrl_if.slave bus
);

   localparam int CW = $clog2(FREEZE_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_PLAY   = 3'd1,
      S_FREEZE = 3'd2,
      S_SPAWN  = 3'd3,
      S_OVER   = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_prev_p1, r_prev_p2;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic        r_serv, w_serv_nxt;
   logic        r_freeze, w_freeze_nxt;
   logic        r_reset, w_reset_nxt;
   logic [11:0] r_x, w_x_nxt;
   logic [11:0] r_y;
   logic [1:0]  r_win, w_win_nxt;
   logic        r_led, w_led_nxt;
   logic        w_inc1, w_inc2, w_dec, w_cnt_done;

`ifdef SERVE_BLINK_EN
   localparam int BW = $clog2(BLINK_CYCLES) + 1;
   logic [BW-1:0] r_bcnt, w_bcnt_nxt;
`endif

   // A falling score means the judge restarted the match.
   assign w_inc1     = (bus.score_player1 != r_prev_p1) && (bus.score_player1 > r_prev_p1);
   assign w_inc2     = (bus.score_player2 != r_prev_p2) && (bus.score_player2 > r_prev_p2);
   assign w_dec      = (bus.score_player1 < r_prev_p1) || (bus.score_player2 < r_prev_p2);
   assign w_cnt_done = (r_cnt == CW'(FREEZE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_INIT;
         r_prev_p1 <= 4'd0;
         r_prev_p2 <= 4'd0;
         r_cnt     <= '0;
         r_serv    <= 1'b0;
         r_freeze  <= 1'b1;
         r_reset   <= 1'b0;
         r_x       <= SERVE_X1;
         r_y       <= SERVE_Y;
         r_win     <= 2'b00;
         r_led     <= 1'b0;
`ifdef SERVE_BLINK_EN
         r_bcnt    <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_prev_p1 <= bus.score_player1;
         r_prev_p2 <= bus.score_player2;
         r_cnt     <= w_cnt_nxt;
         r_serv    <= w_serv_nxt;
         r_freeze  <= w_freeze_nxt;
         r_reset   <= w_reset_nxt;
         r_x       <= w_x_nxt;
         r_y       <= SERVE_Y;
         r_win     <= w_win_nxt;
         r_led     <= w_led_nxt;
`ifdef SERVE_BLINK_EN
         r_bcnt    <= w_bcnt_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_serv_nxt  = r_serv;
      unique case (r_state)
         S_INIT: begin
            w_state_nxt = S_SPAWN;
            w_serv_nxt  = 1'b0;
         end
         S_PLAY: begin
            if (bus.endgame) begin
               w_state_nxt = S_OVER;
            end else if (w_dec) begin
               w_state_nxt = S_SPAWN;
               w_serv_nxt  = 1'b0;
            end else if (w_inc1) begin
               // Simultaneous points resolve to player 1.
               w_state_nxt = S_FREEZE;
               w_serv_nxt  = 1'b0;
            end else if (w_inc2) begin
               w_state_nxt = S_FREEZE;
               w_serv_nxt  = 1'b1;
            end
         end
         S_FREEZE: begin
            if (bus.endgame)     w_state_nxt = S_OVER;
            else if (w_cnt_done) w_state_nxt = S_SPAWN;
         end
         S_SPAWN: w_state_nxt = S_PLAY;
         S_OVER: begin
            if (w_dec) begin
               w_state_nxt = S_SPAWN;
               w_serv_nxt  = 1'b0;
            end
         end
         default: w_state_nxt = S_INIT;
      endcase
      w_cnt_nxt = ((r_state == S_FREEZE) && (w_state_nxt == S_FREEZE)) ? r_cnt + 1'b1 : '0;
   end

   // Outputs are decoded from the next state so they land in flops aligned with r_state.
   always_comb begin
      w_freeze_nxt = (w_state_nxt != S_PLAY);
      w_reset_nxt  = (w_state_nxt == S_SPAWN);
      w_x_nxt      = r_x;
      if (w_state_nxt == S_SPAWN)
         w_x_nxt = w_serv_nxt ? SERVE_X2 : SERVE_X1;
      w_win_nxt = 2'b00;
      if (w_state_nxt == S_OVER) begin
         if (r_state == S_OVER)
            w_win_nxt = r_win;
         else
            w_win_nxt = (bus.score_player1 >= bus.score_player2) ? 2'b01 : 2'b10;
      end
`ifdef SERVE_BLINK_EN
      w_led_nxt  = 1'b0;
      w_bcnt_nxt = '0;
      if (w_state_nxt == S_FREEZE) begin
         if (r_state != S_FREEZE) begin
            w_led_nxt = 1'b1;
         end else if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
            w_led_nxt = ~r_led;
         end else begin
            w_led_nxt  = r_led;
            w_bcnt_nxt = r_bcnt + 1'b1;
         end
      end
`else
      w_led_nxt = (w_state_nxt == S_FREEZE);
`endif
   end

   assign bus.ball_freeze    = r_freeze;
   assign bus.ball_reset     = r_reset;
   assign bus.ball_xspawn    = r_x;
   assign bus.ball_yspawn    = r_y;
   assign bus.serving_player = r_serv;
   assign bus.winner         = r_win;
   assign bus.point_led      = r_led;

endmodule
